// File: rtl/spi_slave_pkg.sv
// Shared SPI definitions: default word width and slave FSM state encodings.
// The encodings match the master side so traces line up across both ends of the link.
package spi_slave_pkg;

    localparam int SPI_WIDTH = 8;

    localparam logic ST_IDLE   = 1'b0;
    localparam logic ST_ACTIVE = 1'b1;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous input, with single-cycle rise/fall
// pulses derived from the synchronised level.
module spi_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], din};
        prev_d = sync_q[STAGES-1];
    end

    // Reset to the idle level of the line so release never produces a false edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise = sync_q[STAGES-1] & ~prev_q;
    assign fall = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave: oversamples SCLK/CS_n/MOSI in the clk domain, shifts words MSB-first,
// returns a buffered tx word on MISO and reports each received word with a 1-cycle pulse.
module spi_slave
    import spi_slave_pkg::*;
#(
    parameter int                    DATA_WIDTH  = SPI_WIDTH,
    parameter int                    SYNC_STAGES = 2,
    parameter logic [DATA_WIDTH-1:0] TX_DEFAULT  = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sclk,
    input  logic                  cs_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  tx_underrun,
    output logic                  busy
);

    localparam int                CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    logic sclk_rise, sclk_fall, cs_rise, cs_fall, s_mosi;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
        .clk  (clk),
        .rst  (reset),
        .din  (sclk),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .clk  (clk),
        .rst  (reset),
        .din  (cs_n),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    // Same depth as the sclk path so s_mosi is aligned with the detected sclk edge.
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    assign mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    assign s_mosi      = mosi_sync_q[SYNC_STAGES-1];

    logic                  state_q, state_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] txbuf_q, txbuf_d;
    logic                  txfull_q, txfull_d;
    logic [DATA_WIDTH-1:0] shift_tx_q, shift_tx_d;
    logic [DATA_WIDTH-2:0] shift_rx_q, shift_rx_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  underrun_q, underrun_d;
    logic                  miso_q, miso_d;

    logic                  tx_wr;
    logic                  word_start;
    logic [DATA_WIDTH-1:0] rx_word;

    assign tx_wr   = tx_valid & ~txfull_q;
    assign rx_word = {shift_rx_q, s_mosi};

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        txbuf_d    = txbuf_q;
        txfull_d   = txfull_q;
        shift_tx_d = shift_tx_q;
        shift_rx_d = shift_rx_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        underrun_d = 1'b0;
        miso_d     = miso_q;
        word_start = 1'b0;

        if (tx_wr) begin
            txbuf_d  = tx_data;
            txfull_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d    = ST_ACTIVE;
                    bit_cnt_d  = '0;
                    word_start = 1'b1;
                end
            end
            default: begin
                if (sclk_rise) begin
                    shift_rx_d = rx_word[DATA_WIDTH-2:0];
                    if (bit_cnt_q == LAST_BIT) begin
                        rx_data_d  = rx_word;
                        rx_valid_d = 1'b1;
                        bit_cnt_d  = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
                // A CS rise wins over a coincident SCLK fall: no new word is started.
                if (cs_rise) begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = '0;
                end else if (sclk_fall) begin
                    if (bit_cnt_q != '0) begin
                        miso_d     = shift_tx_q[DATA_WIDTH-2];
                        shift_tx_d = shift_tx_q << 1;
                    end else begin
                        word_start = 1'b1;
                    end
                end
            end
        endcase

        if (word_start) begin
            if (txfull_q) begin
                shift_tx_d = txbuf_q;
                txfull_d   = 1'b0;
            end else if (tx_wr) begin
                shift_tx_d = tx_data;
                txfull_d   = 1'b0;
            end else begin
                shift_tx_d = TX_DEFAULT;
                underrun_d = 1'b1;
            end
            miso_d = shift_tx_d[DATA_WIDTH-1];
        end

        if (state_d == ST_IDLE) begin
            miso_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mosi_sync_q <= '0;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            txbuf_q     <= '0;
            txfull_q    <= 1'b0;
            shift_tx_q  <= '0;
            shift_rx_q  <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
            miso_q      <= 1'b0;
        end else begin
            mosi_sync_q <= mosi_sync_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            txbuf_q     <= txbuf_d;
            txfull_q    <= txfull_d;
            shift_tx_q  <= shift_tx_d;
            shift_rx_q  <= shift_rx_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            underrun_q  <= underrun_d;
            miso_q      <= miso_d;
        end
    end

    assign miso        = miso_q;
    assign miso_oe     = (state_q == ST_ACTIVE);
    assign busy        = (state_q == ST_ACTIVE);
    assign tx_ready    = ~txfull_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_underrun = underrun_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a behavioural mode-0 master drives frames, a monitor
// records rx/underrun pulses, and each scenario task checks against hand-computed values.
`timescale 1ns/1ps
module tb_spi_slave;

    logic       clk = 1'b0;
    logic       reset, sclk, cs_n, mosi, tx_valid;
    logic [7:0] tx_data;
    logic       miso, miso_oe, tx_ready, rx_valid, tx_underrun, busy;
    logic [7:0] rx_data;

    int n_checks = 0;
    int n_fail   = 0;
    int rx_cnt   = 0;
    int ur_cnt   = 0;
    logic [7:0] rx_last = '0;
    logic [7:0] rx_hist [0:63];

    spi_slave #(.DATA_WIDTH(8), .SYNC_STAGES(2), .TX_DEFAULT(8'h00)) dut (
        .clk         (clk),
        .reset       (reset),
        .sclk        (sclk),
        .cs_n        (cs_n),
        .mosi        (mosi),
        .miso        (miso),
        .miso_oe     (miso_oe),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_underrun (tx_underrun),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid) begin
            rx_hist[rx_cnt % 64] <= rx_data;
            rx_last <= rx_data;
            rx_cnt  <= rx_cnt + 1;
        end
        if (tx_underrun) ur_cnt <= ur_cnt + 1;
    end

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tx_write(input logic [7:0] d);
        int t = 0;
        tx_data  = d;
        tx_valid = 1'b1;
        while (!tx_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (tx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL tx_write_timeout: tx_ready=%b required 1", tx_ready);
        end
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Master: words packed MSB-first in mo[15:8], mo[7:0]; CS rises with the final SCLK fall.
    task automatic spi_xfer(input logic [15:0] mo, input int nw, output logic [15:0] mi);
        mi   = '0;
        cs_n = 1'b0;
        clks(2);
        for (int k = 0; k < 8 * nw; k++) begin
            mosi = mo[15-k];
            clks(4);
            mi[15-k] = miso;
            sclk = 1'b1;
            clks(4);
            sclk = 1'b0;
            if (k == 8 * nw - 1) cs_n = 1'b1;
        end
        mosi = 1'b0;
        clks(8);
    endtask

    task automatic test_reset;
        reset = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0; tx_valid = 1'b0; tx_data = '0;
        clks(3);
        n_checks++;
        if ({miso, miso_oe, rx_data, rx_valid, tx_ready, tx_underrun, busy} !== 14'b00_00000000_0_1_0_0) begin
            n_fail++;
            $display("FAIL reset_state: miso=%b oe=%b rx=%h rv=%b rdy=%b ur=%b busy=%b",
                     miso, miso_oe, rx_data, rx_valid, tx_ready, tx_underrun, busy);
        end
        reset = 1'b0;
        clks(3);
    endtask

    task automatic test_single;
        logic [15:0] mi;
        int r0, u0;
        tx_write(8'hB5);
        n_checks++;
        if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL single_preload_ready: got %b want 0", tx_ready); end
        r0 = rx_cnt; u0 = ur_cnt;
        spi_xfer({8'hCA, 8'h00}, 1, mi);
        n_checks++;
        if (mi[15:8] !== 8'hB5) begin n_fail++; $display("FAIL single_miso: got %h want b5", mi[15:8]); end
        n_checks++;
        if (rx_cnt - r0 !== 1) begin n_fail++; $display("FAIL single_rx_count: got %0d want 1", rx_cnt - r0); end
        n_checks++;
        if (rx_data !== 8'hCA) begin n_fail++; $display("FAIL single_rx_data: got %h want ca", rx_data); end
        n_checks++;
        if (ur_cnt - u0 !== 0) begin n_fail++; $display("FAIL single_underrun: got %0d want 0", ur_cnt - u0); end
        n_checks++;
        if ({tx_ready, miso_oe, busy} !== 3'b100) begin
            n_fail++; $display("FAIL single_idle: rdy/oe/busy got %b want 100", {tx_ready, miso_oe, busy});
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] mi;
        int r0, u0;
        tx_write(8'hF0);
        r0 = rx_cnt; u0 = ur_cnt;
        fork
            spi_xfer({8'hD6, 8'hB5}, 2, mi);
            begin clks(12); tx_write(8'hCC); end
        join
        n_checks++;
        if (mi !== 16'hF0CC) begin n_fail++; $display("FAIL burst_miso: got %h want f0cc", mi); end
        n_checks++;
        if (rx_cnt - r0 !== 2) begin n_fail++; $display("FAIL burst_rx_count: got %0d want 2", rx_cnt - r0); end
        n_checks++;
        if (rx_hist[r0 % 64] !== 8'hD6) begin n_fail++; $display("FAIL burst_rx0: got %h want d6", rx_hist[r0 % 64]); end
        n_checks++;
        if (rx_hist[(r0 + 1) % 64] !== 8'hB5) begin
            n_fail++; $display("FAIL burst_rx1: got %h want b5", rx_hist[(r0 + 1) % 64]);
        end
        n_checks++;
        if (ur_cnt - u0 !== 0) begin n_fail++; $display("FAIL burst_underrun: got %0d want 0", ur_cnt - u0); end
    endtask

    task automatic test_underrun;
        logic [15:0] mi;
        int r0, u0;
        r0 = rx_cnt; u0 = ur_cnt;
        spi_xfer({8'h53, 8'h00}, 1, mi);
        n_checks++;
        if (mi[15:8] !== 8'h00) begin n_fail++; $display("FAIL underrun_miso: got %h want 00", mi[15:8]); end
        n_checks++;
        if (ur_cnt - u0 !== 1) begin n_fail++; $display("FAIL underrun_pulses: got %0d want 1", ur_cnt - u0); end
        n_checks++;
        if (rx_cnt - r0 !== 1 || rx_last !== 8'h53) begin
            n_fail++; $display("FAIL underrun_rx: count %0d data %h want 1 53", rx_cnt - r0, rx_last);
        end
    endtask

    task automatic test_abort;
        logic [15:0] mi;
        int r0;
        r0 = rx_cnt;
        cs_n = 1'b0;
        clks(2);
        for (int k = 0; k < 5; k++) begin
            mosi = k[0];
            clks(4); sclk = 1'b1;
            clks(4); sclk = 1'b0;
        end
        clks(3);
        n_checks++;
        if ({miso_oe, busy} !== 2'b11) begin n_fail++; $display("FAIL abort_active: oe/busy got %b want 11", {miso_oe, busy}); end
        cs_n = 1'b1;
        clks(3);
        n_checks++;
        if ({miso_oe, busy} !== 2'b00) begin n_fail++; $display("FAIL abort_oe: oe/busy got %b want 00", {miso_oe, busy}); end
        clks(6);
        n_checks++;
        if (rx_cnt - r0 !== 0) begin n_fail++; $display("FAIL abort_no_rx: got %0d want 0", rx_cnt - r0); end
        spi_xfer({8'h25, 8'h00}, 1, mi);
        n_checks++;
        if (rx_cnt - r0 !== 1 || rx_data !== 8'h25) begin
            n_fail++; $display("FAIL abort_next_frame: count %0d data %h want 1 25", rx_cnt - r0, rx_data);
        end
    endtask

    task automatic test_reset_mid;
        logic [15:0] mi;
        tx_write(8'hA5);
        cs_n = 1'b0;
        clks(2);
        for (int k = 0; k < 3; k++) begin
            mosi = 1'b1;
            clks(4); sclk = 1'b1;
            if (k < 2) begin clks(4); sclk = 1'b0; end
        end
        clks(3);
        reset = 1'b1;
        #1;
        n_checks++;
        if ({miso, miso_oe, rx_data, rx_valid, tx_ready, tx_underrun, busy} !== 14'b00_00000000_0_1_0_0) begin
            n_fail++;
            $display("FAIL reset_mid_state: miso=%b oe=%b rx=%h rv=%b rdy=%b ur=%b busy=%b",
                     miso, miso_oe, rx_data, rx_valid, tx_ready, tx_underrun, busy);
        end
        sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
        clks(3);
        reset = 1'b0;
        clks(3);
        tx_write(8'h96);
        spi_xfer({8'h3C, 8'h00}, 1, mi);
        n_checks++;
        if (rx_last !== 8'h3C || mi[15:8] !== 8'h96) begin
            n_fail++; $display("FAIL reset_mid_recover: rx %h miso %h want 3c 96", rx_last, mi[15:8]);
        end
    endtask

    task automatic test_cs_high;
        logic [15:0] mi;
        int r0;
        logic oe_seen;
        tx_write(8'h77);
        r0 = rx_cnt;
        oe_seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            mosi = ~k[0];
            clks(3); oe_seen |= miso_oe | busy; sclk = 1'b1;
            clks(3); oe_seen |= miso_oe | busy; sclk = 1'b0;
        end
        clks(6);
        n_checks++;
        if (rx_cnt - r0 !== 0) begin n_fail++; $display("FAIL cs_high_rx: got %0d want 0", rx_cnt - r0); end
        n_checks++;
        if (oe_seen !== 1'b0) begin n_fail++; $display("FAIL cs_high_oe: got %b want 0", oe_seen); end
        n_checks++;
        if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL cs_high_ready: got %b want 0", tx_ready); end
        spi_xfer({8'h11, 8'h00}, 1, mi);
        n_checks++;
        if (mi[15:8] !== 8'h77 || rx_last !== 8'h11) begin
            n_fail++; $display("FAIL cs_high_drain: miso %h rx %h want 77 11", mi[15:8], rx_last);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_underrun();
        test_abort();
        test_reset_mid();
        test_cs_high();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
